// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grant / access / response sequencer with
// alignment and range checking. DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0).
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_done,
  output logic              p1_done,
  output logic              p0_err,
  output logic              p1_err,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                grant, win1, legal, in_access;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win1 = p1_req & ~p0_req;
`else
  logic lw_q, lw_d;
  // On a tie the port that did not win last time takes the grant.
  assign win1 = p1_req & (~p0_req | ~lw_q);
`endif

  assign grant  = (state_q == S_IDLE) & ~reset & (p0_req | p1_req);
  assign p0_gnt = grant & ~win1;
  assign p1_gnt = grant & win1;

  assign legal     = (addr_q[1:0] == 2'b00) && (addr_q <= ADDR_W'(MEM_BYTES - 4));
  assign in_access = (state_q == S_ACCESS);
  assign mem_en    = in_access & legal;
  assign mem_we    = in_access & legal & we_q;
  assign mem_addr  = in_access ? addr_q : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

  assign p0_done  = done0_q;
  assign p1_done  = done1_q;
  assign p0_err   = err0_q;
  assign p1_err   = err1_q;
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    lw_d     = lw_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          port_d  = win1;
          we_d    = win1 ? p1_we    : p0_we;
          addr_d  = win1 ? p1_addr  : p0_addr;
          wdata_d = win1 ? p1_wdata : p0_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          lw_d    = win1;
`endif
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT: begin
        if (legal && !we_q) begin
          if (port_q) rdata1_d = mem_rdata;
          else        rdata0_d = mem_rdata;
        end
        if (port_q) begin
          done1_d = 1'b1;
          err1_d  = ~legal;
        end else begin
          done0_d = 1'b1;
          err0_d  = ~legal;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      lw_q     <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      lw_q     <= lw_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-byte word memory model
// (synchronous 1-cycle read behind mem_en).
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MB = 64;

  logic          clk = 1'b0, reset = 1'b1;
  logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [MB/4];
  int n_cmp = 0, n_bad = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .p0_err(p0_err), .p1_err(p1_err), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"}, {30'd0, p1_gnt, p0_gnt}, 32'd0);
    check({tag, " done/err"}, {28'd0, p1_done, p0_done, p1_err, p0_err}, 32'd0);
    check({tag, " mem_ctl"}, {30'd0, mem_en, mem_we}, 32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " p0_rdata"}, p0_rdata, 32'd0);
    check({tag, " p1_rdata"}, p1_rdata, 32'd0);
  endtask

  // Single p0 access; checks grant, strobe and the response at T+3.
  task automatic p0_access(input string tag, input logic [31:0] addr, input logic ok,
                           input logic [31:0] exp_rdata);
    p0_req = 1; p0_we = 0; p0_addr = addr;
    #1;
    check({tag, " gnt"}, {31'd0, p0_gnt}, 32'd1);
    step(); p0_req = 0;
    check({tag, " mem_en"}, {31'd0, mem_en}, {31'd0, ok});
    if (ok) check({tag, " mem_addr"}, mem_addr, addr);
    step();
    check({tag, " early done"}, {31'd0, p0_done}, 32'd0);
    step();
    check({tag, " done"}, {31'd0, p0_done}, 32'd1);
    check({tag, " err"}, {31'd0, p0_err}, {31'd0, ~ok});
    check({tag, " rdata"}, p0_rdata, exp_rdata);
  endtask

  initial begin
    for (int i = 0; i < MB/4; i++) mem[i] = 32'h0;
    mem[2]  = 32'hDEADBEEF;
    mem[15] = 32'hA5A50F0F;
    mem_rdata = '0;

    // Reset with a pending request: no grant while reset is high.
    p0_req = 1; p0_addr = 32'd8;
    step(); step();
    check("gnt during reset", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    p0_req = 0;
    step(); reset = 0; #1;
    check_all_zero("post reset");

    // Single read, port 0.
    p0_access("rd p0 @8", 32'd8, 1'b1, 32'hDEADBEEF);
    step();

    // Write then read, port 1.
    p1_req = 1; p1_we = 1; p1_addr = 32'h10; p1_wdata = 32'h12345678;
    #1;
    check("wr p1 gnt", {30'd0, p1_gnt, p0_gnt}, 32'd2);
    step(); p1_req = 0;
    check("wr p1 mem_ctl", {30'd0, mem_en, mem_we}, 32'd3);
    check("wr p1 mem_addr", mem_addr, 32'h10);
    check("wr p1 mem_wdata", mem_wdata, 32'h12345678);
    step(); step();
    check("wr p1 done/err", {30'd0, p1_done, p1_err}, 32'd2);
    check("wr p1 rdata kept", p1_rdata, 32'd0);
    p1_req = 1; p1_we = 0;
    #1;
    check("rd p1 gnt", {31'd0, p1_gnt}, 32'd1);
    step(); p1_req = 0;
    step(); step();
    check("rd p1 done", {31'd0, p1_done}, 32'd1);
    check("rd p1 rdata", p1_rdata, 32'h12345678);
    check("p0 rdata unchanged", p0_rdata, 32'hDEADBEEF);

    // Continuous contention; the last winner was port 1.
    p0_req = 1; p0_we = 0; p0_addr = 32'd8;
    p1_req = 1; p1_we = 0; p1_addr = 32'h10;
    #1;
    for (int k = 0; k < 12; k++) begin
      logic [31:0] exp;
      exp = 32'd0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      if (k % 3 == 0) exp = 32'd1;
`else
      if (k % 3 == 0) exp = ((k / 3) % 2 == 0) ? 32'd1 : 32'd2;
`endif
      check($sformatf("contend T+%0d gnt", k), {30'd0, p1_gnt, p0_gnt}, exp);
      step();
      if (k == 9) begin p0_req = 0; p1_req = 0; end
    end
    step();

    // Illegal addresses leave p0_rdata alone; top legal word still works.
    p0_access("rd p0 @6", 32'd6, 1'b0, 32'hDEADBEEF);
    step();
    p0_access("rd p0 @62", MB - 2, 1'b0, 32'hDEADBEEF);
    step();
    p0_access("rd p0 @60", MB - 4, 1'b1, 32'hA5A50F0F);
    step();

    // Reset in the ACCESS cycle of a p1 read.
    p1_req = 1; p1_we = 0; p1_addr = 32'h0;
    #1;
    check("rst p1 gnt", {31'd0, p1_gnt}, 32'd1);
    step();
    reset = 1; p0_req = 1; p0_addr = 32'd8;
    #1;
    check("gnt while reset", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    step();
    check_all_zero("after mid reset");
    reset = 0;
    #1;
    check("post reset tie gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    step(); p0_req = 0; p1_req = 0;
    check("no p1 done T+3", {30'd0, p1_done, p1_err}, 32'd0);
    step();
    check("no p1 done T+4", {31'd0, p1_done}, 32'd0);
    step();
    check("p0 done after reset", {30'd0, p1_done, p0_done}, 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the byte-addressed data memory behind the MEM stage. It shares one memory access port between the CPU MEM stage (port 0) and the program/data loader (port 1). Each access is sequenced through a three-cycle grant/access/response FSM, and the arbiter checks word alignment and address range. It sits between the pipeline's MEM stage and the data memory array, which has a synchronous, 1-cycle-latency read.

## Interface
Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data word width; fixed at 4 bytes
- MEM_BYTES, 64, memory size in bytes; legal word addresses are 0..MEM_BYTES-4

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- p0_req, p1_req  in  1  access request; held with the address and data fields until grant
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  ADDR_W  byte address
- p0_wdata, p1_wdata  in  DATA_W  write data
- p0_gnt, p1_gnt  out  1  combinational one-cycle grant pulse
- p0_done, p1_done  out  1  registered one-cycle completion pulse
- p0_err, p1_err  out  1  qualifies done; illegal address
- p0_rdata, p1_rdata  out  DATA_W  read data holding register
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

## Operation
- FSM states are IDLE, ACCESS and WAIT. Reset enters IDLE.
- **IDLE.** If any req is high:
  - Select the winner and pulse its gnt.
  - Latch the winner's addr, we and wdata, plus its port id, into request registers.
  - Move to ACCESS.
  - With no req, stay in IDLE.
- **Winner selection (round robin).** A lone requester always wins. When both request, the port not granted last wins. The last-winner register resets to 1, so port 0 wins the first tie.
- **Legality check.** The request is illegal when addr[1:0] != 0 or addr > MEM_BYTES-4. The check is evaluated on the latched address.
- **ACCESS.**
  - Legal request: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from the latches.
  - Illegal request: mem_en=0. Go to WAIT.
- **WAIT.**
  - Legal read: capture mem_rdata into the winner's rdata register at the end of the cycle.
  - Set the winner's done (and err if illegal) for the next cycle.
  - Return to IDLE.
- **Rdata register updates.** A port's rdata register changes only on a legal read to that port. Writes and errors leave it unchanged.
- **Request handling.** A requester keeps req and its fields stable until gnt. After gnt it may drop req or present a new request immediately. A new request is queued in the arbiter only by virtue of being held; nothing is buffered.
- **Outputs when idle.** mem_* outputs are 0 outside ACCESS.

## Timing
- **Access sequence.** With grant in cycle T:
  - mem_en is high in T+1.
  - mem_rdata is sampled in T+2.
  - done/err/rdata are visible in T+3.
- **Throughput.** The FSM is in IDLE again at T+3 and may grant in that same cycle. Back-to-back access is therefore one per 3 cycles.
- **Simultaneous requests.** When both ports request continuously, grants alternate 0,1,0,1 in cycles T, T+3, T+6, …
- **Reset values.** All outputs are 0 during and after reset, including rdata registers, done, err, gnt and mem_*. The request latches are cleared. The last-winner register is set to 1.
- **Reset mid-operation.** The in-flight access is dropped. No done is issued. A write already strobed in ACCESS is not retracted.
- **Request during reset.** gnt stays 0 while reset is high. Arbitration resumes in the first cycle after reset deasserts.

## Configuration
- **DMEM_ARB_FIXED_PRIO_EN defined:** port 0 wins every tie. The last-winner register is not implemented, and port 1 may starve.
- **DMEM_ARB_FIXED_PRIO_EN undefined (default):** round-robin selection as described in Operation.

## Test plan
- **Single read, port 0.** Preload mem[8..11]=0xDEADBEEF. p0 reads addr 8 → p0_gnt at T, mem_en/mem_addr=8 at T+1, p0_done=1, p0_err=0, p0_rdata=0xDEADBEEF at T+3.
- **Write then read, port 1.** p1 writes 0x12345678 to addr 0x10 → mem_we=1 at T+1, p1_done at T+3. A following p1 read of 0x10 returns 0x12345678. p0_rdata is unchanged.
- **Continuous contention.** Both ports request continuously → grants 0,1,0,1 at T, T+3, T+6, T+9. Under DMEM_ARB_FIXED_PRIO_EN, grants are all port 0.
- **Illegal addresses.** A p0 read of addr 6, or of addr MEM_BYTES-2 → mem_en stays 0, p0_done=1 and p0_err=1 at T+3, p0_rdata retains its previous value.
- **Reset mid-access.** Assert reset at T+1 of a p1 read → no p1_done. All outputs are 0 the cycle after reset. With both ports requesting after release, port 0 is granted first.
